// File: rtl/hera_pkg.sv
// Shared HERA core definitions: address widths and the return-stack strobe FSM states.
package hera_pkg;
  localparam int ROM_AW = 10;
  localparam int PC_W   = 16;

  typedef enum logic {
    IDLE      = 1'b0,
    RET_ISSUE = 1'b1
  } ret_state_t;
endpackage

// File: rtl/ret_stack_mem.sv
// Return-address register file: one synchronous write port, one asynchronous read of registered contents.
module ret_stack_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 10,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [AW-1:0]    wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [AW-1:0]    rdata_o
);
  logic [AW-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ret_stack.sv
// Hardware return-address stack: captures pc+1 on CALL, hands the popped address to the PC unit with a one-cycle strobe.
import hera_pkg::*;

module ret_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = ROM_AW,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call,
  input  logic             ret,
  input  logic             stall,
  input  logic             flush,
  input  logic [PC_W-1:0]  cur_pc,
  output logic             ret_pc,
  output logic [AW-1:0]    ret_addr,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic             unf
);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [AW-1:0]  PC_ONE   = AW'(1);

  ret_state_t       state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [AW-1:0]    ret_addr_q, ret_addr_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  logic [PTR_W-1:0] sp, top_idx, waddr;
  logic [AW-1:0]    push_val, rd_data;
  logic             empty_w, full_w, push_req, pop_req, push_ok, pop_ok;
  logic             unused_pc_hi;

  // The stack pointer is the count modulo DEPTH; the full case wraps sp to 0, which is never written.
  assign sp       = count_q[PTR_W-1:0];
  assign top_idx  = sp - PTR_W'(1);
  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CNT_FULL);

  assign push_val     = cur_pc[AW-1:0] + PC_ONE;
  assign unused_pc_hi = ^cur_pc[PC_W-1:AW];

  assign push_req = call & ~stall & ~flush;
  assign pop_req  = ret  & ~stall & ~flush;
  assign pop_ok   = pop_req & ~empty_w;
  // A tail call overwrites the top in place, so it is accepted even when full.
  assign push_ok  = push_req & (pop_ok | ~full_w);
  assign waddr    = pop_ok ? top_idx : sp;

  ret_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (waddr),
    .wdata_i (push_val),
    .raddr_i (top_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    count_d    = count_q;
    state_d    = IDLE;
    ret_addr_d = ret_addr_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (push_ok && !pop_ok)  count_d = count_q + CNT_ONE;
      if (pop_ok && !push_req) count_d = count_q - CNT_ONE;
      if (push_req && !pop_ok && full_w) ovf_d = 1'b1;
      if (pop_req && empty_w) unf_d = 1'b1;
      if (pop_ok) begin
        ret_addr_d = rd_data;
        state_d    = RET_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ret_addr_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ret_addr_q <= ret_addr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign ret_pc   = (state_q == RET_ISSUE);
  assign ret_addr = ret_addr_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: expected return addresses are queued at issue and matched by a strobe monitor.
module tb_ret_stack;
  logic        clk = 1'b0;
  logic        rst, call, ret, stall, flush;
  logic [15:0] cur_pc;
  logic        ret_pc, empty, full, ovf, unf;
  logic [9:0]  ret_addr;
  logic [4:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobes = 0;
  int exp_strobes = 0;
  logic [9:0] exp_q [$];

  ret_stack dut (
    .clk      (clk),
    .rst      (rst),
    .call     (call),
    .ret      (ret),
    .stall    (stall),
    .flush    (flush),
    .cur_pc   (cur_pc),
    .ret_pc   (ret_pc),
    .ret_addr (ret_addr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive one cycle of decoder inputs, then return 1ns after the capturing edge.
  task automatic op(input logic c, input logic r, input logic s, input logic f, input logic [15:0] pc);
    call = c; ret = r; stall = s; flush = f; cur_pc = pc;
    @(posedge clk); #1;
    call = 0; ret = 0; stall = 0; flush = 0; cur_pc = 16'h0;
  endtask

  task automatic expect_ret(input logic [9:0] a);
    exp_q.push_back(a);
    exp_strobes++;
  endtask

  // Monitor: every strobe consumes one queued expectation.
  always @(posedge clk) begin
    #2;
    if (ret_pc) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_strobe: ret_addr 0x%0h, none expected", ret_addr);
      end else begin
        chk("ret_addr", ret_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; call = 0; ret = 0; stall = 0; flush = 0; cur_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ret_pc", ret_pc, 0);
    chk("rst_ret_addr", ret_addr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);

    // Basic call/return
    op(1, 0, 0, 0, 16'h0012);
    chk("call1_count", count, 1);
    expect_ret(10'h013);
    op(0, 1, 0, 0, 16'h0);
    chk("ret1_strobe", ret_pc, 1);
    chk("ret1_count", count, 0);
    chk("ret1_empty", empty, 1);
    op(0, 0, 0, 0, 16'h0);
    chk("ret1_strobe_drop", ret_pc, 0);

    // Stall suppresses both requests and leaves flags alone
    op(0, 1, 1, 0, 16'h0);
    chk("stall_ret_unf", unf, 0);
    op(1, 0, 1, 0, 16'h0123);
    chk("stall_call_count", count, 0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) op(1, 0, 0, 0, 16'h0100 + 16'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("pre_ovf", ovf, 0);
    op(1, 0, 0, 0, 16'h0200);
    chk("ovf_flag", ovf, 1);
    chk("ovf_count", count, 16);

    // Drain back-to-back: LIFO order, strobe held high across pops
    for (int i = 0; i < 16; i++) begin
      expect_ret(10'h110 - 10'(i));
      op(0, 1, 0, 0, 16'h0);
      chk("drain_strobe", ret_pc, 1);
    end
    chk("drain_empty", empty, 1);
    op(0, 0, 0, 0, 16'h0);
    chk("drain_strobe_drop", ret_pc, 0);

    // Underflow
    op(0, 1, 0, 0, 16'h0);
    chk("unf_flag", unf, 1);
    chk("unf_no_strobe", ret_pc, 0);
    chk("unf_ret_addr_held", ret_addr, 10'h101);

    // Tail call with address wrap
    op(1, 0, 0, 0, 16'h004F);
    expect_ret(10'h050);
    op(1, 1, 0, 0, 16'h03FF);
    chk("tail_count", count, 1);
    expect_ret(10'h000);
    op(0, 1, 0, 0, 16'h0);
    chk("tail_pop_count", count, 0);
    op(0, 0, 0, 0, 16'h0);

    // Flush with 3 entries; a concurrent call is ignored
    op(1, 0, 0, 0, 16'h0001);
    op(1, 0, 0, 0, 16'h0002);
    op(1, 0, 0, 0, 16'h0003);
    chk("preflush_count", count, 3);
    op(1, 0, 0, 1, 16'h0055);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf_kept", ovf, 1);
    chk("flush_unf_kept", unf, 1);

    // Tail call on empty stack behaves as push only; upper pc bits ignored
    op(1, 1, 0, 0, 16'hF02A);
    chk("tail_empty_count", count, 1);
    chk("tail_empty_no_strobe", ret_pc, 0);
    expect_ret(10'h02B);
    op(0, 1, 0, 0, 16'h0);
    op(0, 0, 0, 0, 16'h0);

    // Reset overrides a pop in the same cycle; no strobe follows
    op(1, 0, 0, 0, 16'h0007);
    rst = 1;
    op(0, 1, 0, 0, 16'h0);
    rst = 0;
    chk("rst2_strobe", ret_pc, 0);
    chk("rst2_count", count, 0);
    chk("rst2_ovf", ovf, 0);
    chk("rst2_unf", unf, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    chk("strobe_total", strobes, exp_strobes);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Hardware return-address stack for the HERA core. It is the producer side of the return-address path that the PC unit consumes.
- On a CALL it captures the return address (current pc + 1). On a RETURN it supplies the saved address as a registered value, together with a return strobe, to the PC unit.
- Sits between the decoder, the PC unit and the PC unit's npc/return inputs. It replaces the RAM-held return address.

Parameters:
- DEPTH, 16, number of stack entries (power of two, 2..64)
- AW, 10, return-address width (matches the ROM address width)
- PTR_W, 4, pointer width, log2(DEPTH)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- call  in  1  decoder: CALL executing this cycle
- ret  in  1  decoder: RETURN executing this cycle
- stall  in  1  decoder hold; when 1, call/ret are ignored
- flush  in  1  discard all entries (context switch)
- cur_pc  in  16  current pc from the PC unit
- ret_pc  out  1  one-cycle strobe to the PC unit: ret_addr is valid
- ret_addr  out  AW  popped return address, held until the next pop
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  PTR_W+1  number of valid entries
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=1 at posedge): sp=0, count=0, ret_pc=0, ret_addr=0, ovf=0, unf=0, FSM=IDLE. Memory contents are don't-care. empty=1, full=0.
- Storage: DEPTH x AW register array. sp points to the next free slot. Top of stack is mem[sp-1].
- Push value is cur_pc[AW-1:0] + 1, truncated modulo 2^AW; wrap 0x3FF -> 0x000 is legal. cur_pc[15:AW] is ignored.
- Effective requests: push = call & ~stall; pop = ret & ~stall.
- Push only:
  - not full: mem[sp] <= value; sp++; count++.
  - full: no write, sp unchanged, ovf <= 1.
- Pop only:
  - not empty: ret_addr <= mem[sp-1]; sp--; count--; FSM IDLE -> RET_ISSUE.
  - empty: ret_addr unchanged, ovf/unf: unf <= 1, no strobe.
- Push and pop in the same cycle (tail call):
  - not empty: ret_addr <= old top; mem[sp-1] <= new value; sp and count unchanged; strobe issued.
  - empty: treated as push only; unf <= 1.
- FSM:
  - IDLE: ret_pc=0.
  - RET_ISSUE: ret_pc=1 for exactly one cycle, then back to IDLE.
  - Latency: ret asserted in cycle N -> ret_pc=1 and ret_addr valid in cycle N+1.
  - A pop while in RET_ISSUE is accepted; FSM stays in RET_ISSUE, so ret_pc stays high for a second cycle with the new ret_addr.
- flush (priority below rst, above call/ret): sp=0, count=0, FSM=IDLE, ret_pc=0; ovf/unf unchanged; any call/ret in the same cycle is ignored.
- Reset mid-RET_ISSUE: ret_pc drops in the reset cycle; no strobe afterwards.
- Sticky flags clear only on rst.
- Memory is written only on an accepted push or a tail call. Reads are of registered array contents.

Decomposition:
- Shared package hera_pkg:
  - ROM_AW = 10
  - PC_W = 16
  - ret_state_t enum {IDLE, RET_ISSUE}
- One natural sub-module, ret_stack_mem: DEPTH x AW register file with one write port and one read port at index sp-1. The pointer/count/FSM logic stays in ret_stack.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, empty=1, ret_pc=0, ret_addr=0x000, ovf=unf=0.
- Basic call/return:
  - call with cur_pc=0x0012 -> count=1.
  - ret next cycle -> one cycle later ret_pc=1 for exactly 1 cycle, ret_addr=0x013, count=0, empty=1.
- Nesting and full:
  - 16 calls with cur_pc=0x100..0x10F -> full=1.
  - 17th call (cur_pc=0x200) -> ovf=1, count stays 16.
  - 16 rets -> ret_addr 0x110, 0x10F, ..., 0x101 in LIFO order.
- Underflow: ret while empty -> unf=1, ret_pc stays 0, ret_addr unchanged. stall=1 with ret -> no flag change.
- Tail call:
  - Stack holds 0x050; call with cur_pc=0x3FF and ret in the same cycle -> next cycle ret_pc=1, ret_addr=0x050, count=1.
  - Following ret -> ret_addr=0x000 (wrap).
- Back-to-back and flush:
  - Two consecutive rets -> ret_pc high 2 cycles with successive addresses.
  - flush with 3 entries held -> count=0, empty=1, ovf/unf preserved.
